// File: rtl/jk_excitation_sequencer.sv
// Drives a bank of external JK flip-flops toward a requested state, verifies the
// fed-back Q outputs and re-drives up to MAX_RETRY times before flagging an error.
module jk_excitation_sequencer #(
  parameter int WIDTH       = 4,
  parameter int TOGGLE_MODE = 0,
  parameter int MAX_RETRY   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] TGT,
  input  logic             TGT_VALID,
  output logic             TGT_READY,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tgt_r, tgt_nxt;
  logic [WIDTH-1:0] j_nxt, k_nxt;
  logic [2:0]       retry, retry_nxt;
  logic             done_nxt, err_nxt;

  // Returns {J, K} for moving q to t.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    if (TOGGLE_MODE != 0) return {q ^ t, q ^ t};
    else                  return {~q & t, q & ~t};
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      tgt_r <= '0;
      retry <= '0;
      J     <= '0;
      K     <= '0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_nxt;
      tgt_r <= tgt_nxt;
      retry <= retry_nxt;
      J     <= j_nxt;
      K     <= k_nxt;
      DONE  <= done_nxt;
      ERR   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (TGT_VALID) state_nxt = DRIVE;
      DRIVE:   state_nxt = CHECK;
      CHECK: begin
        if (Q_FB == tgt_r || retry >= RETRY_LIMIT) state_nxt = IDLE;
        else                                       state_nxt = DRIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // J/K default to zero so they are only non-zero for the cycle spent in DRIVE.
  always_comb begin
    tgt_nxt   = tgt_r;
    retry_nxt = retry;
    j_nxt     = '0;
    k_nxt     = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (TGT_VALID) begin
          tgt_nxt        = TGT;
          retry_nxt      = '0;
          {j_nxt, k_nxt} = excite(Q_FB, TGT);
        end
      end
      CHECK: begin
        if (Q_FB == tgt_r) begin
          done_nxt = 1'b1;
        end else if (retry < RETRY_LIMIT) begin
          retry_nxt      = retry + 3'd1;
          {j_nxt, k_nxt} = excite(Q_FB, tgt_r);
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign TGT_READY = (state == IDLE);
  assign BUSY      = (state == DRIVE) || (state == CHECK);

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Scoreboarded bench: two sequencer instances (set/reset and toggle excitation),
// each driving a modelled JK flip-flop bank whose Q feeds back to the sequencer.
module tb_jk_excitation_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [3:0] tgt0 = '0, tgt1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [3:0] qfb0, qfb1, j0, k0, j1, k1;
  logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;

  logic [3:0] q0 = '0, q1 = '0, ld_val0 = '0, ld_val1 = '0;
  logic       ld0 = 1'b0, ld1 = 1'b0, stuck0 = 1'b0;

  int cyc = 0, n_cmp = 0, n_bad = 0, inv_bad = 0;

  typedef struct { int kind; int lat; logic [3:0] q; } exp_t;
  exp_t sb[$];

  jk_excitation_sequencer #(.WIDTH(4), .TOGGLE_MODE(0), .MAX_RETRY(2)) dut0 (
    .CLK(CLK), .RST(RST), .TGT(tgt0), .TGT_VALID(v0), .TGT_READY(rdy0),
    .Q_FB(qfb0), .J(j0), .K(k0), .BUSY(busy0), .DONE(done0), .ERR(err0));

  jk_excitation_sequencer #(.WIDTH(4), .TOGGLE_MODE(1), .MAX_RETRY(2)) dut1 (
    .CLK(CLK), .RST(RST), .TGT(tgt1), .TGT_VALID(v1), .TGT_READY(rdy1),
    .Q_FB(qfb1), .J(j1), .K(k1), .BUSY(busy1), .DONE(done1), .ERR(err1));

  always @(posedge CLK) cyc <= cyc + 1;

  // JK flip-flop banks with a preload port; bank 0 can be forced stuck at zero.
  always @(posedge CLK) begin
    if (ld0) q0 <= ld_val0;
    else for (int i = 0; i < 4; i++)
      case ({j0[i], k0[i]})
        2'b10:   q0[i] <= 1'b1;
        2'b01:   q0[i] <= 1'b0;
        2'b11:   q0[i] <= ~q0[i];
        default: q0[i] <= q0[i];
      endcase
    if (ld1) q1 <= ld_val1;
    else for (int i = 0; i < 4; i++)
      case ({j1[i], k1[i]})
        2'b10:   q1[i] <= 1'b1;
        2'b01:   q1[i] <= 1'b0;
        2'b11:   q1[i] <= ~q1[i];
        default: q1[i] <= q1[i];
      endcase
  end
  assign qfb0 = stuck0 ? 4'b0000 : q0;
  assign qfb1 = q1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (done0 && err0) inv_bad++;
      if (done1 && err1) inv_bad++;
      if ((j0 & k0) != 4'b0000) inv_bad++;
      if (rdy0 && ((j0 | k0) != 4'b0000)) inv_bad++;
      if (rdy1 && ((j1 | k1) != 4'b0000)) inv_bad++;
    end
  end

  task automatic preload(input int sel, input logic [3:0] val);
    @(negedge CLK);
    if (sel == 0) begin ld_val0 = val; ld0 = 1'b1; end
    else          begin ld_val1 = val; ld1 = 1'b1; end
    @(negedge CLK);
    ld0 = 1'b0; ld1 = 1'b0;
  endtask

  task automatic accept(input int sel, input logic [3:0] t, output int acc);
    @(negedge CLK);
    if (sel == 0) begin tgt0 = t; v0 = 1'b1; end
    else          begin tgt1 = t; v1 = 1'b1; end
    @(negedge CLK);
    acc = cyc;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  // Waits (bounded) for DONE/ERR; kind 1=DONE, 2=ERR, 0=timeout. Also counts
  // later cycles where J equals jpat (re-drives).
  task automatic wait_result(input int sel, input int acc, input logic [3:0] jpat,
                             output int kind, output int lat, output int redrv);
    kind = 0; lat = -1; redrv = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (sel == 0 && jpat != 4'b0000 && j0 === jpat) redrv++;
      if ((sel == 0) ? done0 : done1) begin kind = 1; lat = cyc - acc; return; end
      if ((sel == 0) ? err0  : err1)  begin kind = 2; lat = cyc - acc; return; end
    end
  endtask

  task automatic test_reset;
    v0 = 1'b1; tgt0 = 4'b1111;
    @(negedge CLK); @(negedge CLK);
    n_cmp++;
    if ({j0, k0, done0, err0, busy0, rdy0} !== 12'b0000_0000_0001) begin
      n_bad++;
      $display("FAIL reset_dut0 got j=%b k=%b d=%b e=%b busy=%b rdy=%b want 0 0 0 0 0 1",
               j0, k0, done0, err0, busy0, rdy0);
    end
    n_cmp++;
    if ({j1, k1, done1, err1, busy1, rdy1} !== 12'b0000_0000_0001) begin
      n_bad++;
      $display("FAIL reset_dut1 got j=%b k=%b d=%b e=%b busy=%b rdy=%b want 0 0 0 0 0 1",
               j1, k1, done1, err1, busy1, rdy1);
    end
    v0 = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_set_reset_excitation;
    int acc, kind, lat, rd; exp_t e;
    preload(0, 4'b0000);
    accept(0, 4'b1010, acc);
    sb.push_back('{1, 2, 4'b1010});
    n_cmp++;
    if (j0 !== 4'b1010 || k0 !== 4'b0000 || busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL sr_drive got j=%b k=%b busy=%b want j=1010 k=0000 busy=1", j0, k0, busy0);
    end
    wait_result(0, acc, 4'b0000, kind, lat, rd);
    e = sb.pop_front();
    n_cmp++;
    if (kind !== e.kind || lat !== e.lat || qfb0 !== e.q) begin
      n_bad++;
      $display("FAIL sr_result got kind=%0d lat=%0d q=%b want kind=%0d lat=%0d q=%b",
               kind, lat, qfb0, e.kind, e.lat, e.q);
    end
  endtask

  task automatic test_toggle_excitation;
    int acc, kind, lat, rd; exp_t e;
    preload(1, 4'b1100);
    accept(1, 4'b0110, acc);
    sb.push_back('{1, 2, 4'b0110});
    n_cmp++;
    if (j1 !== 4'b1010 || k1 !== 4'b1010) begin
      n_bad++;
      $display("FAIL tog_drive got j=%b k=%b want j=1010 k=1010", j1, k1);
    end
    wait_result(1, acc, 4'b0000, kind, lat, rd);
    e = sb.pop_front();
    n_cmp++;
    if (kind !== e.kind || lat !== e.lat || qfb1 !== e.q) begin
      n_bad++;
      $display("FAIL tog_result got kind=%0d lat=%0d q=%b want kind=%0d lat=%0d q=%b",
               kind, lat, qfb1, e.kind, e.lat, e.q);
    end
  endtask

  task automatic test_retry_error;
    int acc, kind, lat, rd; exp_t e;
    stuck0 = 1'b1;
    accept(0, 4'b0001, acc);
    sb.push_back('{2, 6, 4'b0000});
    n_cmp++;
    if (j0 !== 4'b0001 || k0 !== 4'b0000) begin
      n_bad++;
      $display("FAIL retry_drive got j=%b k=%b want j=0001 k=0000", j0, k0);
    end
    wait_result(0, acc, 4'b0001, kind, lat, rd);
    e = sb.pop_front();
    n_cmp++;
    if (kind !== e.kind || lat !== e.lat) begin
      n_bad++;
      $display("FAIL retry_result got kind=%0d lat=%0d want kind=%0d lat=%0d",
               kind, lat, e.kind, e.lat);
    end
    n_cmp++;
    if (rd !== 2) begin
      n_bad++;
      $display("FAIL retry_redrives got %0d want 2", rd);
    end
    stuck0 = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc1, acc2, kind, lat, rd; exp_t e;
    preload(0, 4'b0000);
    @(negedge CLK);
    tgt0 = 4'b0011; v0 = 1'b1;
    @(negedge CLK);
    acc1 = cyc;
    sb.push_back('{1, 2, 4'b0011});
    tgt0 = 4'b1111;
    @(negedge CLK);
    @(negedge CLK);
    e = sb.pop_front();
    n_cmp++;
    if (done0 !== 1'b1 || rdy0 !== 1'b1 || (cyc - acc1) !== e.lat || qfb0 !== e.q) begin
      n_bad++;
      $display("FAIL b2b_first got done=%b rdy=%b lat=%0d q=%b want done=1 rdy=1 lat=%0d q=%b",
               done0, rdy0, cyc - acc1, qfb0, e.lat, e.q);
    end
    tgt0 = 4'b0101;
    @(negedge CLK);
    acc2 = cyc;
    v0 = 1'b0;
    sb.push_back('{1, 2, 4'b0101});
    n_cmp++;
    if ((acc2 - acc1) !== 3 || j0 !== 4'b0100 || k0 !== 4'b0010) begin
      n_bad++;
      $display("FAIL b2b_second_drive got spacing=%0d j=%b k=%b want spacing=3 j=0100 k=0010",
               acc2 - acc1, j0, k0);
    end
    wait_result(0, acc2, 4'b0000, kind, lat, rd);
    e = sb.pop_front();
    n_cmp++;
    if (kind !== e.kind || lat !== e.lat || qfb0 !== e.q) begin
      n_bad++;
      $display("FAIL b2b_second_result got kind=%0d lat=%0d q=%b want kind=%0d lat=%0d q=%b",
               kind, lat, qfb0, e.kind, e.lat, e.q);
    end
  endtask

  task automatic test_reset_mid_drive;
    int acc, kind, lat, rd, pulses; exp_t e;
    preload(0, 4'b0101);
    accept(0, 4'b1111, acc);
    n_cmp++;
    if (j0 !== 4'b1010) begin
      n_bad++;
      $display("FAIL mid_pre_drive got j=%b want 1010", j0);
    end
    #1 RST = 1'b1;
    #1;
    n_cmp++;
    if (j0 !== 4'b0000 || k0 !== 4'b0000 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_async_clear got j=%b k=%b busy=%b rdy=%b want 0000 0000 0 1",
               j0, k0, busy0, rdy0);
    end
    tgt0 = 4'b0000; v0 = 1'b1;
    @(negedge CLK); @(negedge CLK);
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_no_accept_in_reset got busy=%b want 0", busy0);
    end
    v0 = 1'b0;
    RST = 1'b0;
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      if (done0 || err0) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL mid_no_pulse got %0d pulses want 0", pulses);
    end
    accept(0, 4'b1001, acc);
    sb.push_back('{1, 2, 4'b1001});
    n_cmp++;
    if (j0 !== 4'b1000 || k0 !== 4'b0100) begin
      n_bad++;
      $display("FAIL mid_recover_drive got j=%b k=%b want j=1000 k=0100", j0, k0);
    end
    wait_result(0, acc, 4'b0000, kind, lat, rd);
    e = sb.pop_front();
    n_cmp++;
    if (kind !== e.kind || lat !== e.lat || qfb0 !== e.q) begin
      n_bad++;
      $display("FAIL mid_recover_result got kind=%0d lat=%0d q=%b want kind=%0d lat=%0d q=%b",
               kind, lat, qfb0, e.kind, e.lat, e.q);
    end
  endtask

  task automatic test_equal_target;
    int acc, kind, lat, rd; exp_t e;
    preload(0, 4'b0101);
    accept(0, 4'b0101, acc);
    sb.push_back('{1, 2, 4'b0101});
    n_cmp++;
    if (j0 !== 4'b0000 || k0 !== 4'b0000 || busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL eq_drive got j=%b k=%b busy=%b want 0000 0000 1", j0, k0, busy0);
    end
    wait_result(0, acc, 4'b0000, kind, lat, rd);
    e = sb.pop_front();
    n_cmp++;
    if (kind !== e.kind || lat !== e.lat || qfb0 !== e.q) begin
      n_bad++;
      $display("FAIL eq_result got kind=%0d lat=%0d q=%b want kind=%0d lat=%0d q=%b",
               kind, lat, qfb0, e.kind, e.lat, e.q);
    end
  endtask

  task automatic test_invariants;
    n_cmp++;
    if (inv_bad !== 0) begin
      n_bad++;
      $display("FAIL invariants got %0d violations want 0", inv_bad);
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_set_reset_excitation;
    test_toggle_excitation;
    test_retry_error;
    test_back_to_back;
    test_reset_mid_drive;
    test_equal_target;
    test_invariants;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
